// File: rtl/median_pkg.sv
// Shared pixel and window definitions for sliding_window_gen and median_filter.
package median_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int PIX_W      = 3 * DATA_WIDTH;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] red;
    logic [DATA_WIDTH-1:0] green;
    logic [DATA_WIDTH-1:0] blue;
  } pixel_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } swg_state_t;

  // Flattened window element index: row offset x (0 = top), column offset y (0 = left).
  function automatic int unsigned win_idx(input int unsigned x,
                                          input int unsigned y,
                                          input int unsigned k);
    return x * k + y;
  endfunction

endpackage

// File: rtl/sliding_window_gen_line_buffer.sv
// Single-row pixel delay: o_dout is the pixel written DEPTH enables earlier.
module line_buffer #(
  parameter int DEPTH = 318,
  parameter int WIDTH = 24
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_ptr;

  // Read-before-write at the same slot gives exactly DEPTH enables of delay.
  assign o_dout = r_mem[r_ptr];

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      r_mem[r_ptr] <= i_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (i_en) begin
      r_ptr <= (r_ptr == AW'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/sliding_window_gen.sv
// Raster-stream K x K window generator feeding median_filter.
// Define SWG_WIN_INDEX_EN to add win_row/win_col window-centre outputs.
module sliding_window_gen
  import median_pkg::*;
#(
  parameter int WINDOW_SIZE = 3,
  parameter int DATA_WIDTH  = median_pkg::DATA_WIDTH,
  parameter int IMG_WIDTH   = 318,
  parameter int IMG_HEIGHT  = 305,
  localparam int K  = WINDOW_SIZE,
  localparam int PW = 3 * DATA_WIDTH,
  localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1,
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PW-1:0]     in_pixel,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [K*K*PW-1:0] win_data,
  output logic              win_last,
  output logic              frame_done
`ifdef SWG_WIN_INDEX_EN
  ,
  output logic [RW-1:0]     win_row,
  output logic [CW-1:0]     win_col
`endif
);

  swg_state_t       r_state;
  logic [CW-1:0]    r_col;
  logic [RW-1:0]    r_row;
  logic             r_valid;
  logic [K*K*PW-1:0] r_data;
  logic             r_last;
  logic             r_done;
`ifdef SWG_WIN_INDEX_EN
  logic [RW-1:0]    r_win_row;
  logic [CW-1:0]    r_win_col;
`endif

  logic             w_accept;
  logic             w_emit;
  logic             w_col_last;
  logic             w_row_last;
  logic [PW-1:0]    w_win [K][K];
  logic [K*K*PW-1:0] w_flat;

  assign in_ready   = !rst && (r_state == ST_RUN) && (!r_valid || win_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_col_last = (r_col == CW'(IMG_WIDTH - 1));
  assign w_row_last = (r_row == RW'(IMG_HEIGHT - 1));
  assign w_emit     = w_accept && (int'(r_row) >= K - 1) && (int'(r_col) >= K - 1);

  generate
    if (K > 1) begin : g_hist
      logic [PW-1:0] w_lb_in  [K-1];
      logic [PW-1:0] w_lb_out [K-1];
      logic [PW-1:0] w_col    [K];
      logic [PW-1:0] r_hist   [K][K-1];

      assign w_lb_in[0] = in_pixel;
      for (genvar i = 1; i < K - 1; i++) begin : g_chain
        assign w_lb_in[i] = w_lb_out[i-1];
      end

      for (genvar i = 0; i < K - 1; i++) begin : g_lb
        line_buffer #(
          .DEPTH (IMG_WIDTH),
          .WIDTH (PW)
        ) u_line_buffer (
          .i_clk  (clk),
          .i_rst  (rst),
          .i_en   (w_accept),
          .i_din  (w_lb_in[i]),
          .o_dout (w_lb_out[i])
        );
      end

      // Deepest buffer holds the oldest row, so it feeds the top of the new column.
      always_comb begin
        for (int unsigned x = 0; x < K; x++) begin
          w_col[x] = in_pixel;
        end
        for (int unsigned x = 0; x < K - 1; x++) begin
          w_col[x] = w_lb_out[K-2-x];
        end
        for (int unsigned x = 0; x < K; x++) begin
          for (int unsigned y = 0; y < K - 1; y++) begin
            w_win[x][y] = r_hist[x][y];
          end
          w_win[x][K-1] = w_col[x];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int unsigned x = 0; x < K; x++) begin
            for (int unsigned y = 0; y < K - 1; y++) begin
              r_hist[x][y] <= '0;
            end
          end
        end else if (w_accept) begin
          for (int unsigned x = 0; x < K; x++) begin
            for (int unsigned y = 0; y < K - 1; y++) begin
              r_hist[x][y] <= w_win[x][y+1];
            end
          end
        end
      end
    end else begin : g_single
      always_comb begin
        w_win[0][0] = in_pixel;
      end
    end
  endgenerate

  always_comb begin
    w_flat = '0;
    for (int unsigned x = 0; x < K; x++) begin
      for (int unsigned y = 0; y < K; y++) begin
        w_flat[win_idx(x, y, K)*PW +: PW] = w_win[x][y];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_RUN;
      r_col     <= '0;
      r_row     <= '0;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_last    <= 1'b0;
      r_done    <= 1'b0;
`ifdef SWG_WIN_INDEX_EN
      r_win_row <= '0;
      r_win_col <= '0;
`endif
    end else begin
      if (w_accept) begin
        r_col <= w_col_last ? '0 : r_col + 1'b1;
        if (w_col_last) begin
          r_row <= r_row + 1'b1;
        end
      end

      // A reload on handoff keeps one window per cycle; otherwise handoff drains.
      if (w_emit) begin
        r_valid   <= 1'b1;
        r_data    <= w_flat;
        r_last    <= w_row_last && w_col_last;
`ifdef SWG_WIN_INDEX_EN
        r_win_row <= r_row - RW'(K / 2);
        r_win_col <= r_col - CW'(K / 2);
`endif
      end else if (r_valid && win_ready) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        ST_RUN: begin
          if (w_accept && w_row_last && w_col_last) begin
            r_state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (r_valid && win_ready && r_last) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_done <= 1'b1;
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  assign win_valid  = r_valid;
  assign win_data   = r_data;
  assign win_last   = r_last;
  assign frame_done = r_done;
`ifdef SWG_WIN_INDEX_EN
  assign win_row    = r_win_row;
  assign win_col    = r_win_col;
`endif

endmodule

// File: doc/sliding_window_gen.md
Name: sliding_window_gen

Overview:
- Streaming window generator that sits directly upstream of median_filter.
- Accepts a raster-order RGB pixel stream and holds WINDOW_SIZE-1 previous rows in line buffers.
- Emits every fully-interior WINDOW_SIZE x WINDOW_SIZE window, flattened, with a valid/ready handshake.
- Replaces frame-sized pixel storage with O(WINDOW_SIZE*IMG_WIDTH) storage.

Parameters:
- WINDOW_SIZE, 3, window edge K; odd, >=1, <= IMG_WIDTH and <= IMG_HEIGHT.
- DATA_WIDTH, 8, bits per colour channel.
- IMG_WIDTH, 318, pixels per row, including any pre-applied padding.
- IMG_HEIGHT, 305, rows per frame.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_pixel is valid.
- in_ready  out  1  block accepts in_pixel this cycle.
- in_pixel  in  3*DATA_WIDTH  pixel_t {red, green, blue}.
- win_valid  out  1  win_data holds a complete window.
- win_ready  in  1  downstream consumes the window.
- win_data  out  K*K*3*DATA_WIDTH  flattened pixel_t array; element x*K+y = row offset x (0 = top), column offset y (0 = left).
- win_last  out  1  qualifies the final window of the frame.
- frame_done  out  1  all windows of the frame have been handed off.

Behaviour:
- Reset: synchronous, active-high. in_ready=0 during reset, win_valid=0, win_data=0, win_last=0, frame_done=0. Counters, window registers and state are cleared; line-buffer contents are don't-care. Reset mid-frame discards the frame; the next accepted pixel is treated as (0,0).
- Accept: a pixel is accepted when in_valid && in_ready. On each accept:
  - col increments and wraps to 0 at IMG_WIDTH-1; row then increments.
  - The K x K shift-register window shifts left by one column. New right column = {line_buf[K-2..0] outputs at col, in_pixel}.
  - Line buffers update: buffer i receives the output of buffer i-1; buffer 0 receives in_pixel.
- Window emit: an accept at (row>=K-1, col>=K-1) loads the output register, and win_valid rises the following cycle (latency 1).
  - Window count = (IMG_WIDTH-K+1)*(IMG_HEIGHT-K+1), in row-major order of window centre.
  - No windows are emitted for col<K-1, so there is no wrap across row boundaries.
- Handshake: in_ready = (state==RUN) && (!win_valid || win_ready).
  - While win_valid && !win_ready: win_data and win_last are held stable, and no pixel is accepted.
  - Simultaneous handoff and accept: the register reloads in the same cycle, giving 1 pixel/cycle throughput.
  - A non-emitting accept during handoff clears win_valid.
- win_last=1 with the window produced by pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
- States:
  - RUN: entered out of reset; accepts pixels.
  - FLUSH: entered after the last pixel is accepted; in_ready=0; waits for the last window handoff.
  - DONE: entered on win_valid && win_ready && win_last; frame_done=1, held until rst; in_ready=0.
- K=1: every pixel is a window; line buffers are absent.
- Widths:
  - col counter is $clog2(IMG_WIDTH) bits; row counter is $clog2(IMG_HEIGHT) bits.
  - No arithmetic is performed on pixel data.

Optional Feature:
- SWG_WIN_INDEX_EN defined: adds output ports win_row [$clog2(IMG_HEIGHT)] and win_col [$clog2(IMG_WIDTH)].
  - These give the window-centre coordinates (row-K/2, col-K/2) of the triggering pixel.
  - They are registered with, and held like, win_data; reset value 0.
- Undefined: those ports and their registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package median_pkg holds:
  - pixel_t packed struct {red, green, blue}, each DATA_WIDTH bits.
  - localparam PIX_W = 3*DATA_WIDTH.
  - Function win_idx(x,y) = x*K+y.
  - median_filter imports the same package.
- One sub-module, line_buffer: single-row delay of depth IMG_WIDTH, width PIX_W, with enable.
  - Output is the pixel written IMG_WIDTH enables earlier.
  - Instantiated K-1 times in a chain.

Test Plan:
- Frame IMG_WIDTH=5, IMG_HEIGHT=4, K=3, pixel i = {i,i,i}, in_valid and win_ready always 1 -> 6 windows. First window red = {0,1,2,5,6,7,10,11,12}, valid 1 cycle after accepting pixel 12. Last window = {7,8,9,12,13,14,17,18,19} with win_last=1. frame_done=1 the cycle after that handoff.
- Same frame, win_ready=0 for 3 cycles while the first window is valid -> win_data stable, in_ready=0 for those 3 cycles, no pixel lost; second window = {1,2,3,6,7,8,11,12,13}.
- in_valid toggled 1/0 every cycle -> identical window sequence; win_valid never asserts without a qualifying accept.
- rst asserted after 9 pixels, then a full frame streamed -> outputs at reset values during reset; next frame windows exactly as in scenario 1.
- K=1, IMG_WIDTH=3, IMG_HEIGHT=2 -> 6 windows equal to pixels 0..5, each 1 cycle after its accept; win_last on pixel 5.
- SWG_WIN_INDEX_EN defined, scenario 1 -> (win_row,win_col) sequence (1,1),(1,2),(1,3),(2,1),(2,2),(2,3).
